tmr_state_accumulator: RTL and testbench

//   Parametrised successor of the 1-bit triplicated toggle FSM: WIDTH-bit state held in three

---
 rtl/tmr_state_accumulator.sv | 77 +++++++
 tb/tb_tmr_state_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmr_state_accumulator.sv
// Triplicated WIDTH-bit state register with a bitwise 2-of-3 vote and continuous scrubbing.
// Flags copy disagreement and counts mismatch cycles in a saturating counter.
module tmr_state_accumulator #(
    parameter int WIDTH    = 8,
    parameter int MODE     = 0,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [WIDTH-1:0]    inA,
    input  logic [WIDTH-1:0]    inB,
    input  logic [WIDTH-1:0]    inC,
    input  logic                enA,
    input  logic                enB,
    input  logic                enC,
    input  logic                errClear,
    output logic [WIDTH-1:0]    outA,
    output logic [WIDTH-1:0]    outB,
    output logic [WIDTH-1:0]    outC,
    output logic                tmrErr,
    output logic [ERRCNT_W-1:0] errCount
);

    logic [WIDTH-1:0]    state_a_q, state_b_q, state_c_q;
    logic [WIDTH-1:0]    next_a, next_b, next_c;
    logic [WIDTH-1:0]    voted_d;
    logic                mismatch;
    logic                tmr_err_q;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    // Add mode drops the carry, so the state wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] upd(input logic [WIDTH-1:0] op,
                                             input logic [WIDTH-1:0] st);
        if (MODE == 1) return st + op;
        else           return st ^ op;
    endfunction

    always_comb begin
        next_a   = enA ? upd(inA, state_a_q) : state_a_q;
        next_b   = enB ? upd(inB, state_b_q) : state_b_q;
        next_c   = enC ? upd(inC, state_c_q) : state_c_q;
        voted_d  = (next_a & next_b) | (next_b & next_c) | (next_a & next_c);
        mismatch = (next_a != next_b) || (next_b != next_c);
    end

    // Clear wins over the old count but still records a same-cycle mismatch.
    always_comb begin
        errcnt_d = errcnt_q;
        if (errClear)
            errcnt_d = ERRCNT_W'(mismatch);
        else if (mismatch && (errcnt_q != {ERRCNT_W{1'b1}}))
            errcnt_d = errcnt_q + ERRCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_a_q <= '0;
            state_b_q <= '0;
            state_c_q <= '0;
            tmr_err_q <= 1'b0;
            errcnt_q  <= '0;
        end else begin
            state_a_q <= voted_d;
            state_b_q <= voted_d;
            state_c_q <= voted_d;
            tmr_err_q <= mismatch;
            errcnt_q  <= errcnt_d;
        end
    end

    assign outA     = state_a_q;
    assign outB     = state_b_q;
    assign outC     = state_c_q;
    assign tmrErr   = tmr_err_q;
    assign errCount = errcnt_q;

endmodule

// File: tb/tb_tmr_state_accumulator.sv
// Scoreboard bench: an XOR-mode instance with an 8-bit counter and an add-mode instance with a
// 2-bit counter share stimulus; a behavioural model predicts every cycle of both.
module tb_tmr_state_accumulator;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] inA, inB, inC;
    logic       enA, enB, enC;
    logic       errClear;
    logic [7:0] oa0, ob0, oc0, oa1, ob1, oc1;
    logic       err0, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    tmr_state_accumulator #(.WIDTH(8), .MODE(0), .ERRCNT_W(8)) dut0 (
        .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC),
        .enA(enA), .enB(enB), .enC(enC), .errClear(errClear),
        .outA(oa0), .outB(ob0), .outC(oc0), .tmrErr(err0), .errCount(cnt0));

    tmr_state_accumulator #(.WIDTH(8), .MODE(1), .ERRCNT_W(2)) dut1 (
        .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC),
        .enA(enA), .enB(enB), .enC(enC), .errClear(errClear),
        .outA(oa1), .outB(ob1), .outC(oc1), .tmrErr(err1), .errCount(cnt1));

    typedef struct packed {
        logic [7:0] a0, b0, c0, a1, b1, c1;
        logic       e0, e1;
        logic [7:0] n0, n1;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model: three copies per instance, plain arithmetic on integers.
    int m_st[2][3];
    int m_err[2];
    int m_cnt[2];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic void model_step(input int d, input logic r, input int ins[3],
                                       input logic ens[3], input logic clr);
        int nx[3];
        int voted;
        int ones;
        bit mm;
        int cmax;
        cmax = (d == 0) ? 255 : 3;
        if (!r) begin
            for (int k = 0; k < 3; k++) m_st[d][k] = 0;
            m_err[d] = 0;
            m_cnt[d] = 0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (!ens[k])     nx[k] = m_st[d][k];
            else if (d == 0) nx[k] = m_st[d][k] ^ ins[k];
            else             nx[k] = (m_st[d][k] + ins[k]) % 256;
        end
        voted = 0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int k = 0; k < 3; k++) ones += (nx[k] >> b) & 1;
            if (ones >= 2) voted += (1 << b);
        end
        mm = !((nx[0] == nx[1]) && (nx[1] == nx[2]));
        for (int k = 0; k < 3; k++) m_st[d][k] = voted;
        m_err[d] = mm ? 1 : 0;
        if (clr)                  m_cnt[d] = mm ? 1 : 0;
        else if (mm && m_cnt[d] < cmax) m_cnt[d] = m_cnt[d] + 1;
    endfunction

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [2:0] en, input logic clr);
        int   ins[3];
        logic ens[3];
        exp_t e;
        rstn = r; inA = a; inB = b; inC = c;
        enA = en[2]; enB = en[1]; enC = en[0]; errClear = clr;
        ins[0] = a; ins[1] = b; ins[2] = c;
        ens[0] = en[2]; ens[1] = en[1]; ens[2] = en[0];
        model_step(0, r, ins, ens, clr);
        model_step(1, r, ins, ens, clr);
        e.a0 = 8'(m_st[0][0]); e.b0 = 8'(m_st[0][1]); e.c0 = 8'(m_st[0][2]);
        e.a1 = 8'(m_st[1][0]); e.b1 = 8'(m_st[1][1]); e.c1 = 8'(m_st[1][2]);
        e.e0 = m_err[0][0];    e.e1 = m_err[1][0];
        e.n0 = 8'(m_cnt[0]);   e.n1 = 8'(m_cnt[1]);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the outputs are registered, so every edge presents a new response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("sb_outA0", oa0, e.a0); chk("sb_outB0", ob0, e.b0); chk("sb_outC0", oc0, e.c0);
            chk("sb_outA1", oa1, e.a1); chk("sb_outB1", ob1, e.b1); chk("sb_outC1", oc1, e.c1);
            chk("sb_tmrErr0", err0, e.e0); chk("sb_tmrErr1", err1, e.e1);
            chk("sb_errCount0", cnt0, e.n0); chk("sb_errCount1", cnt1, e.n1);
        end
    end

    initial begin
        // Reset with every input active.
        step(0, 8'hFF, 8'hFF, 8'hFF, 3'b111, 0);
        step(0, 8'hFF, 8'hFF, 8'hFF, 3'b111, 0);
        chk("rst_outA", oa0, 8'h00); chk("rst_outB", ob0, 8'h00); chk("rst_outC", oc0, 8'h00);
        chk("rst_tmrErr", err0, 0); chk("rst_errCount", cnt0, 0);

        // XOR toggle twice.
        step(1, 8'h5A, 8'h5A, 8'h5A, 3'b111, 0);
        chk("xor_first", oa0, 8'h5A);
        step(1, 8'h5A, 8'h5A, 8'h5A, 3'b111, 0);
        chk("xor_second", ob0, 8'h00); chk("xor_tmrErr", err0, 0);

        // Add with wrap: 0x90 + 0x80 = 0x10, then hold.
        step(0, 8'h00, 8'h00, 8'h00, 3'b111, 0);
        step(1, 8'h90, 8'h90, 8'h90, 3'b111, 0);
        chk("add_0x90", oc1, 8'h90);
        step(1, 8'h80, 8'h80, 8'h80, 3'b111, 0);
        chk("add_wrap", oa1, 8'h10); chk("add_cnt", cnt1, 0);
        step(1, 8'h33, 8'h33, 8'h33, 3'b000, 0);
        chk("add_hold", ob1, 8'h10);

        // Single-copy input fault, then single-copy enable fault.
        step(0, 8'h00, 8'h00, 8'h00, 3'b111, 0);
        step(1, 8'h01, 8'hFF, 8'h01, 3'b111, 0);
        chk("infault_outB", ob0, 8'h01); chk("infault_err", err0, 1);
        chk("infault_cnt", cnt0, 1);
        step(1, 8'h01, 8'h01, 8'h01, 3'b111, 0);
        chk("infault_pulse", err0, 0);
        step(1, 8'h01, 8'h77, 8'h01, 3'b101, 0);
        chk("enfault_outB", ob0, 8'h01); chk("enfault_cnt", cnt0, 2);

        // Saturation of the 2-bit counter in add mode.
        step(1, 8'h00, 8'h00, 8'h00, 3'b111, 1);
        chk("sat_clear0", cnt1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h01, 8'h02, 8'h01, 3'b111, 0);
            chk("sat_cnt", cnt1, (i < 3) ? i + 1 : 3);
            chk("sat_tmrErr", err1, 1);
        end
        step(1, 8'h00, 8'h00, 8'h00, 3'b111, 1);
        chk("sat_clear", cnt1, 0);
        step(1, 8'h01, 8'h02, 8'h01, 3'b111, 1);
        chk("sat_clear_mm", cnt1, 1);

        // Copy B diverges to 0xAA while A/C hold 0x33; vote keeps 0x33, then reset mid-mismatch.
        step(0, 8'h00, 8'h00, 8'h00, 3'b000, 0);
        step(1, 8'h33, 8'h33, 8'h33, 3'b111, 0);
        step(1, 8'h00, 8'h99, 8'h00, 3'b010, 0);
        chk("scrub_outB", ob0, 8'h33); chk("scrub_err", err0, 1);
        step(0, 8'h00, 8'h99, 8'h00, 3'b010, 0);
        chk("midrst_out", oa0, 8'h00); chk("midrst_err", err0, 0); chk("midrst_cnt", cnt0, 0);

        // Randomised traffic: mostly agreeing copies with occasional faults, clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a, b, c;
            logic [2:0] en;
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : a;
            c = ($urandom_range(0, 5) == 0) ? 8'($urandom) : a;
            en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            step(($urandom_range(0, 40) != 0), a, b, c, en, ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        #2;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
